data_memory_responder: RTL

Data-side memory responder for the RISC-V core. It services load/store requests from the core's memory stage over a valid/ready request channel and a valid/ready response channel. It has a configurable fixed access latency and byte-enable writes. It keeps one transaction outstanding at a time and sits between the core's future load/store path and a word-organised storage array.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_array.sv | 32 +++
 rtl/data_memory_responder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-side memory responder.
package dmem_pkg;

  localparam int unsigned DMEM_WORD_W   = 32;
  localparam int unsigned DMEM_BE_W     = 4;
  localparam int unsigned DMEM_ADDR_LSB = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous byte-enable write, combinational read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [IDX_W-1:0]       widx_i,
  input  logic [DMEM_WORD_W-1:0] wdata_i,
  input  logic [DMEM_BE_W-1:0]   be_i,
  input  logic [IDX_W-1:0]       ridx_i,
  output logic [DMEM_WORD_W-1:0] rdata_o
);

  logic [DMEM_WORD_W-1:0] mem_q [DEPTH_WORDS];

  // Byte-masked write; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DMEM_BE_W; b++) begin
        if (be_i[b]) begin
          mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/data_memory_responder.sv
// Data-side memory responder: one outstanding load/store, fixed latency,
// byte-enable stores committed at acceptance.
// Optional build macro DMEM_ERR_CHECK_EN: when defined, misaligned or
// out-of-range accesses report resp_err_o and are suppressed; when undefined,
// the low address bits are ignored and the word index wraps.
// DEPTH_WORDS is assumed to be at most 2**29 so an upper address field exists.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [31:0]            req_addr_i,
  input  logic [DMEM_WORD_W-1:0] req_wdata_i,
  input  logic [DMEM_BE_W-1:0]   req_be_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [DMEM_WORD_W-1:0] resp_rdata_o,
  output logic                   resp_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  dmem_state_t state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   we_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   err_q;
  logic [DMEM_WORD_W-1:0] rdata_q, rdata_d;
  logic                   rerr_q, rerr_d;

  logic                   in_idle;
  logic                   accept;
  logic [IDX_W-1:0]       req_idx;
  logic                   req_err;
  logic                   cap_we;
  logic                   cap_err;
  logic [IDX_W-1:0]       rd_idx;
  logic [DMEM_WORD_W-1:0] arr_rdata;
  logic [DMEM_WORD_W-1:0] cap_rdata;

  assign in_idle = (state_q == IDLE);
  assign accept  = req_valid_i & req_ready_o;
  assign req_idx = req_addr_i[IDX_W+DMEM_ADDR_LSB-1:DMEM_ADDR_LSB];

`ifdef DMEM_ERR_CHECK_EN
  assign req_err = (req_addr_i[DMEM_ADDR_LSB-1:0] != '0) |
                   (|req_addr_i[31:IDX_W+DMEM_ADDR_LSB]);
`else
  logic unused_addr;
  assign req_err     = 1'b0;
  assign unused_addr = ^{req_addr_i[31:IDX_W+DMEM_ADDR_LSB], req_addr_i[DMEM_ADDR_LSB-1:0]};
`endif

  // With LATENCY=1 the response is captured on the acceptance edge itself, so
  // the capture path must look at the live request rather than the registers.
  assign cap_we    = in_idle ? req_we_i : we_q;
  assign cap_err   = in_idle ? req_err  : err_q;
  assign rd_idx    = in_idle ? req_idx  : idx_q;
  assign cap_rdata = (cap_we | cap_err) ? '0 : arr_rdata;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (accept & req_we_i & ~req_err),
    .widx_i  (req_idx),
    .wdata_i (req_wdata_i),
    .be_i    (req_be_i),
    .ridx_i  (rd_idx),
    .rdata_o (arr_rdata)
  );

  // Next-state: accept in IDLE, count down in WAIT, hold RESP until handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = RESP;
            rdata_d = cap_rdata;
            rerr_d  = cap_err;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          rdata_d = cap_rdata;
          rerr_d  = cap_err;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
          rdata_d = '0;
          rerr_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request/response registers; reset drops any transaction.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      if (accept) begin
        we_q  <= req_we_i;
        idx_q <= req_idx;
        err_q <= req_err;
      end
    end
  end

  assign req_ready_o  = in_idle & rst_i;
  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = rerr_q;

endmodule
